// File: rtl/p2_mem_read.sv
// Read-side streamer for the pooling-2 output memory: walks addresses 0..DEPTH-1,
// buffers the latency-1 read data in a 2-entry FIFO and streams it over valid/ready.
module p2_mem_read #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] addr0,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] W_DEPTH    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] W_LAST_IDX = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_W-1:0]  r_issued;
    logic [CNT_W-1:0]  r_xfer;
    logic [ADDR_W-1:0] r_addr;
    logic              r_inflight;
    logic              r_busy;
    logic              r_done;

    logic [DATA_W-1:0] r_fifo [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;

    logic w_rd_en;
    logic w_push;
    logic w_pop;
    logic w_valid;
    logic w_last;
    logic w_last_xfer;

    assign w_valid     = (r_count != 2'd0);
    assign w_last      = w_valid && (r_xfer == W_LAST_IDX);
    assign w_pop       = w_valid && out_ready;
    assign w_push      = r_inflight;
    assign w_last_xfer = w_pop && w_last;

    // Next state and issue decision; a pop this cycle frees a slot for a new read.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_READ;
            end
            S_READ: begin
                w_rd_en = (r_issued < W_DEPTH) &&
                          ((3'({1'b0, r_count}) + 3'(r_inflight)) < (3'd2 + 3'(w_pop)));
                if (w_last_xfer) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (start) w_state_nxt = S_READ;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_READ);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    // Issue/transfer bookkeeping; counters return to zero once the last word leaves.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_issued   <= '0;
            r_xfer     <= '0;
            r_addr     <= '0;
            r_inflight <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_rd_en) begin
                r_addr   <= r_addr + ADDR_W'(1);
                r_issued <= r_issued + CNT_W'(1);
            end
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
                r_xfer   <= r_xfer + CNT_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_last_xfer) begin
                r_issued <= '0;
                r_xfer   <= '0;
            end
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= rdata;
    end

    assign addr0     = r_addr;
    assign rd_en     = w_rd_en;
    assign out_data  = r_fifo[r_rd_ptr];
    assign out_valid = w_valid;
    assign out_last  = w_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_p2_mem_read.sv
// Randomised scoreboard bench for p2_mem_read: memory returns 0x100+addr one cycle
// after rd_en, and every streamed word is checked against an expected-word queue.
module tb_p2_mem_read;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              out_ready = 1'b1;
    logic [ADDR_W-1:0] addr0;
    logic              rd_en;
    logic [DATA_W-1:0] rdata = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic              busy;
    logic              done;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W:0] sb_q [$];

    always #5 clk = ~clk;

    p2_mem_read #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .addr0     (addr0),
        .rd_en     (rd_en),
        .rdata     (rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    // Synchronous memory: valid data only after a read, garbage otherwise.
    always @(posedge clk) begin
        if (rd_en) rdata <= 16'h0100 + 16'(addr0);
        else       rdata <= 16'($urandom);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: scoreboard pops, stall stability and a 2-entry occupancy bound.
    int          occ = 0;
    logic        infl = 1'b0;
    logic        stall_prev = 1'b0;
    logic [15:0] stall_data = '0;

    always @(negedge clk) begin
        logic [DATA_W:0] e;
        logic            pop;
        if (!reset) begin
            chk("fifo_occupancy_le2", int'(occ <= 2), 1);
            chk("valid_vs_buffered", out_valid, int'(occ > 0));
            if (stall_prev) begin
                chk("stall_valid_hold", out_valid, 1);
                chk("stall_data_hold", out_data, stall_data);
            end
            pop = out_valid && out_ready;
            if (pop) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_word", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("out_data", out_data, int'(e[DATA_W-1:0]));
                    chk("out_last", out_last, int'(e[DATA_W]));
                end
            end else if (!out_valid) begin
                chk("last_without_valid", out_last, 0);
            end
            occ        = occ + int'(infl) - int'(pop);
            infl       = rd_en;
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
        end else begin
            occ        = 0;
            infl       = 1'b0;
            stall_prev = 1'b0;
        end
    end

    task automatic push_expected();
        for (int i = 0; i < int'(DEPTH); i++)
            sb_q.push_back({1'(i == int'(DEPTH) - 1), DATA_W'(32'h100 + i)});
    endtask

    // mode 0: ready high, 1: stall cycles 2..10, 2: random ready, 3: start pulsed at cycle 5
    task automatic run(input int mode);
        int c;
        int issue_idx;
        int pre;
        int lasts;
        bit seen;
        push_expected();
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        start     = 1'b0;
        c = 1; issue_idx = 0; pre = 0; lasts = 0; seen = 1'b0;
        while (!seen && c <= 400) begin
            case (mode)
                1:       out_ready = !(c >= 2 && c <= 10);
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
            start = (mode == 3 && c == 5);
            @(negedge clk);
            if (mode == 0 || mode == 3) begin
                chk("rd_en_cycle",     rd_en,     int'(c <= 16));
                chk("out_valid_cycle", out_valid, int'(c >= 3 && c <= 18));
                chk("busy_cycle",      busy,      int'(c <= 18));
                chk("done_cycle",      done,      int'(c >= 19));
            end
            if (rd_en) begin
                chk("addr0_order", addr0, issue_idx);
                issue_idx++;
                if (c <= 10) pre++;
            end
            if (mode == 1 && c >= 3 && c <= 10) begin
                chk("stall_head_valid", out_valid, 1);
                chk("stall_head_data", out_data, 16'h0100);
            end
            if (out_valid && out_ready && out_last) lasts++;
            seen = done;
            step();
            c++;
        end
        start = 1'b0;
        chk("run_completed", int'(seen), 1);
        chk("reads_issued", issue_idx, int'(DEPTH));
        chk("last_count", lasts, 1);
        if (mode == 1) chk("reads_before_stall", pre, 2);
        repeat (3) begin
            @(negedge clk);
            chk("done_sticky", done, 1);
            chk("idle_busy", busy, 0);
            chk("idle_rd_en", rd_en, 0);
            chk("idle_valid", out_valid, 0);
            chk("idle_addr0", addr0, 0);
            step();
        end
        chk("scoreboard_drained", sb_q.size(), 0);
    endtask

    task automatic reset_mid_run();
        push_expected();
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        start     = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            step();
        end
        reset = 1'b1;
        @(negedge clk);
        chk("read_in_flight_at_reset", rd_en, 1);
        step();
        reset = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("rst_addr0", addr0, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        step();
        @(negedge clk);
        chk("rst_read_discarded", out_valid, 0);
        chk("rst_stays_idle", rd_en, 0);
        step();
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("init_addr0", addr0, 0);
        chk("init_rd_en", rd_en, 0);
        chk("init_out_valid", out_valid, 0);
        chk("init_out_last", out_last, 0);
        chk("init_busy", busy, 0);
        chk("init_done", done, 0);
        step();
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_no_read", rd_en, 0);
            chk("idle_not_busy", busy, 0);
            step();
        end
        run(0);
        run(0);
        run(1);
        run(2);
        run(2);
        run(3);
        reset_mid_run();
        run(0);
        run(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/p2_mem_read.md
Name: p2_mem_read

Overview:
- Read-side addresser/streamer for the pooling-2 layer output memory (4x4 pooled map, 16 words).
- It is the reader counterpart to the P2 write counter.
- On `start` it walks addresses 0..15 against the synchronous-read memory and buffers the returned words in a 2-entry FIFO.
- It presents the words in address order to the fully-connected layer over a valid/ready stream, with `out_last` on word 15.

Parameters:
- DATA_W, 16, width of one memory word / output sample
- ADDR_W, 4, memory address width
- DEPTH, 16, number of words read per run (4x4); must equal 2**ADDR_W

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a 16-word read run; sampled only in IDLE or DONE
- addr0  output  ADDR_W  read address to P2 output memory
- rd_en  output  1  memory read enable; one read issued per cycle it is high
- rdata  input  DATA_W  memory read data, valid exactly 1 cycle after rd_en (fixed latency 1)
- out_data  output  DATA_W  stream data (FIFO head)
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data this cycle
- out_last  output  1  high with out_valid on the 16th word (address 15)
- busy  output  1  high in READ state
- done  output  1  high in DONE state; sticky until next start or reset

Behaviour:
- Reset (synchronous, takes priority over all else):
  - State goes to IDLE; addr0=0, rd_en=0, out_valid=0, out_last=0, busy=0, done=0.
  - FIFO is emptied and the issue/transfer counters are cleared.
  - An in-flight read is discarded: rdata in the cycle after reset is not captured.
- States:
  - IDLE: if start, go to READ.
  - READ: issue reads and stream; after the transfer of word 15 (out_valid && out_ready && out_last), go to DONE.
  - DONE: if start, go to READ with a fresh run. The counters and addr0 are already 0, and done drops on entry to READ.
  - start in READ is ignored; there is no restart and no error.
- Issue rule (READ only):
  - rd_en = (issued < DEPTH) && (fifo_count + inflight - pop < 2).
  - inflight = rd_en registered one cycle (0 or 1); pop = out_valid && out_ready.
  - rd_en is combinational from registered state plus out_ready.
- addr0 holds the address of the current issue. It increments after each issued read and wraps 15->0 after the final issue, so it is 0 in DONE/IDLE.
- Capture: rdata is written to the FIFO tail on the cycle after rd_en. The issue rule guarantees no overflow.
  - A simultaneous push and pop is legal and keeps the count.
  - A push to the empty FIFO becomes visible on out_valid the next cycle (no bypass).
- Stream:
  - out_valid = FIFO not empty; out_data = head.
  - out_data must stay stable while out_valid && !out_ready.
  - out_last = out_valid && (head is word index 15).
- Latency and throughput:
  - start sampled at edge E1 gives rd_en/addr0=0 in cycle 1, and out_valid first high in cycle 3.
  - With out_ready held high: one word per cycle, reads in cycles 1..16, outputs in cycles 3..18, done=1 from cycle 19.
- Backpressure: while out_ready is low, at most 2 words are buffered plus 0 outstanding reads, and rd_en stays low. Issue resumes in the same cycle out_ready returns high.
- Counters: issued is 0..16 (5 bits); transferred is 0..16 (5 bits). No arithmetic wraps except addr0.

Test Plan:
- Full rate: memory model returns rdata = 0x100 + addr, out_ready=1, pulse start.
  - rd_en high cycles 1..16 with addr0 0..15.
  - out_data 0x100..0x10F in cycles 3..18, out_last only with 0x10F.
  - done=1 and busy=0 from cycle 19.
- Backpressure: out_ready low from cycle 2 to cycle 10, then high.
  - Exactly 2 reads are issued (addr 0 and 1) before the stall.
  - out_data holds 0x100 stable while stalled.
  - All 16 words are delivered in order with no loss or duplicate.
- Random out_ready (50%):
  - The output sequence is exactly 0x100..0x10F.
  - out_last appears once.
  - The FIFO never exceeds 2 entries (assertion).
- start while busy: start pulsed at cycle 5 of a run.
  - Nothing changes: 16 words delivered, a single done.
- Reset mid-run: reset asserted at cycle 8 with a read in flight.
  - The next cycle shows all outputs at reset values.
  - A later start delivers 0x100..0x10F from address 0.
- Restart from DONE: start pulsed while done=1.
  - done drops the next cycle and rd_en/addr0=0 are issued.
  - A second full 16-word run completes identically.
